// File: rtl/keypad_scan_debounce.sv
// 4x4 matrix keypad column scanner with press/release debounce and a one-cycle valid pulse per key.
// Defining KEY_REPEAT_EN adds auto-repeat pulses every REPEAT_CYCLES cycles while a key stays held.
module keypad_scan_debounce #(
    parameter int SCAN_CYCLES     = 1000,
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int REPEAT_CYCLES   = 400000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows_sync,
    output logic [3:0] cols,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);
    localparam logic [1:0] ST_SCAN     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_HELD     = 2'd2;
    localparam logic [1:0] ST_RELEASE  = 2'd3;

    localparam int DW = $clog2(SCAN_CYCLES);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    if (SCAN_CYCLES < 2 || DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_param_check
        $error("keypad_scan_debounce: cycle parameters must be at least 2");
    end

    // Index of the lowest active-low row; only consulted when some row is low.
    function automatic logic [1:0] lowest_zero(input logic [3:0] r);
        logic [1:0] idx;
        casez (r)
            4'b???0: idx = 2'd0;
            4'b??01: idx = 2'd1;
            4'b?011: idx = 2'd2;
            default: idx = 2'd3;
        endcase
        return idx;
    endfunction

    logic [1:0]    state_r, state_s;
    logic [1:0]    col_r, col_s;
    logic [1:0]    row_r, row_s;
    logic [DW-1:0] dwell_r, dwell_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [3:0]    code_s;
    logic          valid_s;
    logic          held_s;
    logic          row_bit_s;
`ifdef KEY_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES);
    logic [RW-1:0] rep_r, rep_s;
`endif

    // Next-state logic for the scan/debounce/hold/release sequence.
    always_comb begin
        state_s   = state_r;
        col_s     = col_r;
        row_s     = row_r;
        dwell_s   = dwell_r;
        cnt_s     = cnt_r;
        code_s    = key_code;
        valid_s   = 1'b0;
        held_s    = key_held;
        row_bit_s = rows_sync[row_r];
`ifdef KEY_REPEAT_EN
        rep_s     = rep_r;
`endif
        case (state_r)
            ST_SCAN: begin
`ifdef KEY_REPEAT_EN
                rep_s = '0;
`endif
                // Rows are only trusted on the last dwell cycle, after the column has settled.
                if (dwell_r == DW'(SCAN_CYCLES - 1)) begin
                    dwell_s = '0;
                    if (rows_sync != 4'hF) begin
                        row_s   = lowest_zero(rows_sync);
                        cnt_s   = '0;
                        state_s = ST_DEBOUNCE;
                    end else begin
                        col_s = col_r + 2'd1;
                    end
                end else begin
                    dwell_s = dwell_r + DW'(1);
                end
            end
            ST_DEBOUNCE: begin
                if (row_bit_s) begin
                    state_s = ST_SCAN;
                    dwell_s = '0;
                    cnt_s   = '0;
                end else if (cnt_r == CW'(DEBOUNCE_CYCLES - 1)) begin
                    code_s  = {row_r, col_r};
                    valid_s = 1'b1;
                    held_s  = 1'b1;
                    cnt_s   = '0;
                    state_s = ST_HELD;
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end
            ST_HELD: begin
                if (row_bit_s) begin
                    cnt_s   = '0;
                    state_s = ST_RELEASE;
                end else begin
`ifdef KEY_REPEAT_EN
                    if (rep_r == RW'(REPEAT_CYCLES - 1)) begin
                        rep_s   = '0;
                        valid_s = 1'b1;
                    end else begin
                        rep_s = rep_r + RW'(1);
                    end
`else
                    cnt_s = cnt_r;
`endif
                end
            end
            ST_RELEASE: begin
                // The repeat counter is left untouched here so a release glitch resumes it.
                if (!row_bit_s) begin
                    cnt_s   = '0;
                    state_s = ST_HELD;
                end else if (cnt_r == CW'(DEBOUNCE_CYCLES - 1)) begin
                    held_s  = 1'b0;
                    col_s   = col_r + 2'd1;
                    cnt_s   = '0;
                    dwell_s = '0;
                    state_s = ST_SCAN;
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end
            default: begin
                state_s = ST_SCAN;
                dwell_s = '0;
                cnt_s   = '0;
            end
        endcase
    end

    // State and registered outputs, with synchronous reset overriding everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_SCAN;
            col_r     <= 2'd0;
            row_r     <= 2'd0;
            dwell_r   <= '0;
            cnt_r     <= '0;
            cols      <= 4'b1110;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
`ifdef KEY_REPEAT_EN
            rep_r     <= '0;
`endif
        end else begin
            state_r   <= state_s;
            col_r     <= col_s;
            row_r     <= row_s;
            dwell_r   <= dwell_s;
            cnt_r     <= cnt_s;
            cols      <= ~(4'b0001 << col_s);
            key_code  <= code_s;
            key_valid <= valid_s;
            key_held  <= held_s;
`ifdef KEY_REPEAT_EN
            rep_r     <= rep_s;
`endif
        end
    end

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Randomized and directed bench for keypad_scan_debounce with a keypad-physics stimulus,
// a run-length reference model and a scoreboard of expected key codes.
module tb_keypad_scan_debounce;
    localparam int SCAN = 4;
    localparam int DEB  = 8;
    localparam int REP  = 32;
    localparam int M_SCAN = 0;
    localparam int M_DEB  = 1;
    localparam int M_HELD = 2;
    localparam int M_REL  = 3;

    logic       clk;
    logic       reset;
    logic [3:0] rows_sync;
    logic [3:0] cols;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    keypad_scan_debounce #(
        .SCAN_CYCLES    (SCAN),
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_CYCLES  (REP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rows_sync(rows_sync),
        .cols     (cols),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int chk_cnt = 0;
    int pass_cnt = 0;
    int dut_pulses = 0;

    // Reference model: where the scan points and how long the watched row has been steady.
    int         m_mode;
    logic [1:0] m_col;
    logic [1:0] m_row;
    logic [3:0] m_code;
    int         m_tick;
    int         m_run;
    bit         m_held;
`ifdef KEY_REPEAT_EN
    int         m_rep;
`endif
    logic [15:0] keys;
    logic [3:0]  exp_q[$];

    task automatic check(input string name, input int act, input int want);
        chk_cnt++;
        if (act == want) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, want, $time);
    endtask

    task automatic model_reset();
        m_mode = M_SCAN; m_col = 2'd0; m_row = 2'd0; m_code = 4'h0;
        m_tick = 0; m_run = 0; m_held = 1'b0;
`ifdef KEY_REPEAT_EN
        m_rep = 0;
`endif
    endtask

    task automatic emit();
        exp_q.push_back(m_code);
    endtask

    // Physical keypad: a pressed key pulls its row low only while its column is driven.
    function automatic logic [3:0] keypad_rows();
        logic [3:0] rows;
        rows = 4'hF;
        for (int r = 0; r < 4; r++)
            if ((keys & (16'h0001 << (4 * r + int'(m_col)))) != 16'h0000)
                rows = rows & ~(4'b0001 << r);
        return rows;
    endfunction

    task automatic model_step(input logic [3:0] rows, input logic rst);
        if (rst) begin
            model_reset();
            return;
        end
        case (m_mode)
            M_SCAN: begin
`ifdef KEY_REPEAT_EN
                m_rep = 0;
`endif
                m_tick++;
                if (m_tick == SCAN) begin
                    m_tick = 0;
                    if (rows != 4'hF) begin
                        for (int r = 3; r >= 0; r--)
                            if ((rows & (4'b0001 << r)) == 4'h0) m_row = 2'(r);
                        m_mode = M_DEB;
                        m_run = 0;
                    end else begin
                        m_col = m_col + 2'd1;
                    end
                end
            end
            M_DEB: begin
                if (rows[m_row]) begin
                    m_mode = M_SCAN; m_tick = 0;
                end else begin
                    m_run++;
                    if (m_run == DEB) begin
                        m_code = {m_row, m_col};
                        m_held = 1'b1;
                        m_mode = M_HELD;
                        emit();
                    end
                end
            end
            M_HELD: begin
                if (rows[m_row]) begin
                    m_mode = M_REL; m_run = 0;
                end
`ifdef KEY_REPEAT_EN
                else begin
                    m_rep++;
                    if (m_rep == REP) begin
                        m_rep = 0;
                        emit();
                    end
                end
`endif
            end
            default: begin
                if (!rows[m_row]) begin
                    m_mode = M_HELD;
                end else begin
                    m_run++;
                    if (m_run == DEB) begin
                        m_held = 1'b0;
                        m_col = m_col + 2'd1;
                        m_mode = M_SCAN;
                        m_tick = 0;
                    end
                end
            end
        endcase
    endtask

    // Drive one cycle of keypad input at the falling edge and advance the model to match.
    task automatic step_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            rows_sync = keypad_rows();
            model_step(rows_sync, reset);
            @(negedge clk);
        end
    endtask

    task automatic wait_held(input bit want, input int budget, input string name);
        for (int i = 0; i < budget && key_held != want; i++) step_cycles(1);
        check(name, int'(key_held), int'(want));
    endtask

    // Monitor: per-cycle output compare plus scoreboard pop on every key_valid pulse.
    initial begin
        logic [3:0] exp_cols;
        forever begin
            @(posedge clk);
            #1;
            exp_cols = ~(4'b0001 << m_col);
            check("cols", int'(cols), int'(exp_cols));
            check("key_held", int'(key_held), int'(m_held));
            check("key_code", int'(key_code), int'(m_code));
            if (key_valid) begin
                dut_pulses++;
                if (exp_q.size() == 0) check("key_valid_spurious", int'(key_valid), 0);
                else check("pulse_code", int'(key_code), int'(exp_q.pop_front()));
            end else if (exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                check("key_valid_missing", int'(key_valid), 1);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d checks made", chk_cnt);
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int k;
        int hold;
        logic [15:0] saved;
        reset = 1'b1;
        rows_sync = 4'hF;
        keys = 16'h0000;
        model_reset();
        @(negedge clk);
        step_cycles(2);
        check("reset_cols", int'(cols), int'(4'b1110));
        check("reset_held", int'(key_held), 0);
        check("reset_valid", int'(key_valid), 0);
        check("reset_code", int'(key_code), 0);

        // Idle scan: four cycles per column, wrapping 3 -> 0.
        reset = 1'b0;
        step_cycles(4);
        check("scan_col1", int'(cols), int'(4'b1101));
        step_cycles(4);
        check("scan_col2", int'(cols), int'(4'b1011));
        step_cycles(8);
        check("scan_wrap", int'(cols), int'(4'b1110));

        // Key at row 2, column 2.
        p0 = dut_pulses;
        keys = 16'h0001 << 10;
        wait_held(1'b1, 40, "press_a_held");
        step_cycles(20);
        check("press_a_cols", int'(cols), int'(4'b1011));
        check("press_a_code", int'(key_code), 10);
        check("press_a_pulses", dut_pulses - p0, 1);

        keys = 16'h0000;
        wait_held(1'b0, 40, "release_a");
        check("release_a_cols", int'(cols), int'(4'b0111));

        // Bounce on row 1 in column 0: three low samples then high.
        for (int i = 0; i < 64 && !(m_mode == M_SCAN && m_col == 2'd0 && m_tick == 0); i++)
            step_cycles(1);
        p0 = dut_pulses;
        keys = 16'h0001 << 4;
        for (int i = 0; i < 8 && m_mode != M_DEB; i++) step_cycles(1);
        step_cycles(3);
        keys = 16'h0000;
        step_cycles(3);
        check("bounce_pulses", dut_pulses - p0, 0);
        check("bounce_cols", int'(cols), int'(4'b1110));
        check("bounce_held", int'(key_held), 0);

        // Release glitch on key 5.
        p0 = dut_pulses;
        keys = 16'h0001 << 5;
        wait_held(1'b1, 60, "glitch_held");
        step_cycles(3);
        keys = 16'h0000;
        step_cycles(4);
        keys = 16'h0001 << 5;
        step_cycles(10);
        check("glitch_still_held", int'(key_held), 1);
        check("glitch_pulses", dut_pulses - p0, 1);
        check("glitch_code", int'(key_code), 5);
        keys = 16'h0000;
        wait_held(1'b0, 40, "glitch_release");

        // Reset in the middle of debouncing key 3.
        p0 = dut_pulses;
        keys = 16'h0001 << 3;
        for (int i = 0; i < 40 && m_mode != M_DEB; i++) step_cycles(1);
        step_cycles(2);
        reset = 1'b1;
        step_cycles(1);
        check("midreset_cols", int'(cols), int'(4'b1110));
        check("midreset_held", int'(key_held), 0);
        check("midreset_valid", int'(key_valid), 0);
        check("midreset_code", int'(key_code), 0);
        check("midreset_pulses", dut_pulses - p0, 0);
        reset = 1'b0;
        keys = 16'h0000;
        step_cycles(2);

        // Long hold on key 3: auto-repeat only when the feature is built in.
        p0 = dut_pulses;
        keys = 16'h0001 << 3;
        wait_held(1'b1, 60, "long_held");
        step_cycles(80);
`ifdef KEY_REPEAT_EN
        check("long_pulses", dut_pulses - p0, 3);
`else
        check("long_pulses", dut_pulses - p0, 1);
`endif
        keys = 16'h0000;
        wait_held(1'b0, 40, "long_release");

        // Random presses, occasional second keys, release glitches and resets.
        for (int e = 0; e < 60; e++) begin
            k = int'($urandom_range(0, 15));
            keys = 16'h0001 << k;
            if ($urandom_range(0, 3) == 0) keys = keys | (16'h0001 << $urandom_range(0, 15));
            hold = int'($urandom_range(1, 40));
            for (int c = 0; c < hold; c++) begin
                if ($urandom_range(0, 9) == 0) begin
                    saved = keys;
                    keys = 16'h0000;
                    step_cycles(1);
                    keys = saved;
                end else if ($urandom_range(0, 59) == 0) begin
                    reset = 1'b1;
                    step_cycles(1);
                    reset = 1'b0;
                end else begin
                    step_cycles(1);
                end
            end
            keys = 16'h0000;
            step_cycles(int'($urandom_range(1, 30)));
        end

        keys = 16'h0000;
        step_cycles(40);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
